// File: rtl/alu_issue_arbiter_pkg.sv
// Shared issue payload types for the ALU issue arbiter slice.
// Width macros are normally supplied by the core's global defines header.
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 5
`endif

package alu_issue_arbiter_pkg;

   localparam int NUM_ALU_DEFAULT = 2;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       use_imm;
      logic       is_signed;
   } control_t;

   typedef struct packed {
      logic [`REG_VAL_WIDTH-1:0]          src_reg1_val;
      logic [`REG_VAL_WIDTH-1:0]          src_reg2_val;
      logic [`PHYSICAL_REG_NUM_WIDTH-1:0] dst_reg_addr;
      control_t                           control;
      logic [`REG_VAL_WIDTH-1:0]          immediate;
      logic [`INST_ADDR_WIDTH-1:0]        pc;
      logic [`ROB_SIZE_WIDTH-1:0]         rob_tag;
   } alu_issue_t;

   localparam int ALU_ISSUE_W = $bits(alu_issue_t);

endpackage

// File: rtl/alu_issue_arbiter_rr_multi_select.sv
// Round-robin multi-grant selector: pairs the j-th ready requester (from rr_ptr) with the j-th free ALU.
// Latency: purely combinational; backpressure: only free ALUs are assigned, the rest stay pending.
module rr_multi_select #(
   parameter int NUM_REQ       = 8,
   parameter int NUM_ALU       = 2,
   parameter int REQ_IDX_WIDTH = (NUM_REQ <= 1) ? 1 : $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_ALU-1:0]               alu_free,
   input  logic [REQ_IDX_WIDTH-1:0]         rr_ptr,
   output logic [NUM_REQ-1:0]               grant,
   output logic [NUM_ALU-1:0]               sel_vld,
   output logic [NUM_ALU*REQ_IDX_WIDTH-1:0] sel_idx,
   output logic [REQ_IDX_WIDTH-1:0]         next_ptr
);

   logic [NUM_ALU-1:0] avail;
   logic               taken;
   int                 idx;

   always_comb begin
      grant    = '0;
      sel_vld  = '0;
      sel_idx  = '0;
      next_ptr = rr_ptr;
      avail    = alu_free;
      taken    = 1'b0;
      idx      = 0;
      for (int o = 0; o < NUM_REQ; o++) begin
         idx = int'(rr_ptr) + o;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req_valid[idx] && (avail != '0)) begin
            // lowest remaining free ALU goes to the next requester in scan order
            taken = 1'b0;
            for (int k = 0; k < NUM_ALU; k++) begin
               if (avail[k] && !taken) begin
                  avail[k] = 1'b0;
                  taken    = 1'b1;
                  sel_vld[k] = 1'b1;
                  sel_idx[k*REQ_IDX_WIDTH +: REQ_IDX_WIDTH] = REQ_IDX_WIDTH'(idx);
               end
            end
            grant[idx] = 1'b1;
            next_ptr   = (idx + 1 == NUM_REQ) ? '0 : REQ_IDX_WIDTH'(idx + 1);
         end
      end
   end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Issues up to NUM_ALU ready RS entries per cycle to free ALUs; 1-cycle registered rs_valid pulse.
// Backpressure: busy ALUs leave requests pending (RS keeps valid) and count as stall cycles.
module alu_issue_arbiter
   import alu_issue_arbiter_pkg::*;
#(
   parameter int NUM_REQ         = 8,
   parameter int NUM_ALU         = NUM_ALU_DEFAULT,
   parameter int REQ_IDX_WIDTH   = (NUM_REQ <= 1) ? 1 : $clog2(NUM_REQ),
   parameter int STALL_CNT_WIDTH = 32
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ*ALU_ISSUE_W-1:0]   req_payload,
   output logic [NUM_REQ-1:0]               req_grant,
   input  logic [NUM_ALU-1:0]               alu_ready,
   output logic [NUM_ALU-1:0]               rs_valid,
   output logic [NUM_ALU*ALU_ISSUE_W-1:0]   alu_payload,
   input  logic                             flush,
   output logic [STALL_CNT_WIDTH-1:0]       stall_cnt
);

   logic [REQ_IDX_WIDTH-1:0]         rr_ptr;
   logic [REQ_IDX_WIDTH-1:0]         next_ptr;
   logic [NUM_ALU-1:0]               alu_free;
   logic [NUM_REQ-1:0]               sel_grant;
   logic [NUM_ALU-1:0]               sel_vld;
   logic [NUM_ALU*REQ_IDX_WIDTH-1:0] sel_idx;
   alu_issue_t                       issue_pl [NUM_ALU];
   logic                             issue_ok;
   logic                             stall_cyc;

   // an ALU still holding this cycle's pulse is not free even if it reports ready
   assign alu_free = alu_ready & ~rs_valid;

   rr_multi_select #(
      .NUM_REQ       (NUM_REQ),
      .NUM_ALU       (NUM_ALU),
      .REQ_IDX_WIDTH (REQ_IDX_WIDTH)
   ) u_select (
      .req_valid (req_valid),
      .alu_free  (alu_free),
      .rr_ptr    (rr_ptr),
      .grant     (sel_grant),
      .sel_vld   (sel_vld),
      .sel_idx   (sel_idx),
      .next_ptr  (next_ptr)
   );

   assign issue_ok  = !reset && !flush;
   assign req_grant = issue_ok ? sel_grant : '0;
   assign stall_cyc = issue_ok && (req_valid != '0) && (alu_free == '0);

   always_comb begin
      for (int k = 0; k < NUM_ALU; k++) begin
         issue_pl[k] = req_payload[int'(sel_idx[k*REQ_IDX_WIDTH +: REQ_IDX_WIDTH])*ALU_ISSUE_W +: ALU_ISSUE_W];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rs_valid    <= '0;
         alu_payload <= '0;
         rr_ptr      <= '0;
         stall_cnt   <= '0;
      end else begin
         for (int k = 0; k < NUM_ALU; k++) begin
            rs_valid[k] <= sel_vld[k] && !flush;
            if (sel_vld[k] && !flush) begin
               alu_payload[k*ALU_ISSUE_W +: ALU_ISSUE_W] <= issue_pl[k];
            end
         end
         if (!flush && (sel_grant != '0)) begin
            rr_ptr <= next_ptr;
         end
         if (stall_cyc && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scoreboard bench: queue-based pairing model predicts grants, issues, stall count; monitor checks pulses.
module tb_alu_issue_arbiter;
   import alu_issue_arbiter_pkg::*;

   localparam int NR = 4;
   localparam int NA = 2;
   localparam int PW = ALU_ISSUE_W;

   typedef struct {
      logic [PW-1:0] pl;
      int            cyc;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              flush;
   logic [NR-1:0]     req_valid;
   logic [NR*PW-1:0]  req_payload;
   logic [NA-1:0]     alu_ready;
   logic [NR-1:0]     req_grant, req_grant_n;
   logic [NA-1:0]     rs_valid, rs_valid_n;
   logic [NA*PW-1:0]  alu_payload, alu_payload_n;
   logic [31:0]       stall_cnt;
   logic [2:0]        stall_cnt_n;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   exp_t        exp_q [NA][$];
   exp_t        mon_e;
   int          rr     = 0;
   longint      stall  = 0;
   logic [NA-1:0]    busy   = '0;
   logic [NA*PW-1:0] mdl_pl = '0;

   always #5 clk = ~clk;

   alu_issue_arbiter #(.NUM_REQ(NR), .NUM_ALU(NA), .STALL_CNT_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_payload(req_payload),
      .req_grant(req_grant), .alu_ready(alu_ready), .rs_valid(rs_valid),
      .alu_payload(alu_payload), .flush(flush), .stall_cnt(stall_cnt)
   );

   alu_issue_arbiter #(.NUM_REQ(NR), .NUM_ALU(NA), .STALL_CNT_WIDTH(3)) dut_narrow (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_payload(req_payload),
      .req_grant(req_grant_n), .alu_ready(alu_ready), .rs_valid(rs_valid_n),
      .alu_payload(alu_payload_n), .flush(flush), .stall_cnt(stall_cnt_n)
   );

   task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   // monitor: every rs_valid pulse must match the queued expectation for this cycle
   always @(negedge clk) begin
      for (int k = 0; k < NA; k++) begin
         if (exp_q[k].size() > 0 && exp_q[k][0].cyc <= cyc) begin
            mon_e = exp_q[k].pop_front();
            chk("issue_pulse", {{(PW-1){1'b0}}, rs_valid[k]}, 1);
            if (rs_valid[k] === 1'b1) chk("issue_payload", alu_payload[k*PW +: PW], mon_e.pl);
         end else if (rs_valid[k] === 1'b1) begin
            chk("issue_unexpected", {{(PW-1){1'b0}}, rs_valid[k]}, 0);
         end
      end
   end

   task automatic evaluate();
      int fr[$];
      int rq[$];
      int n;
      logic [NR-1:0] eg;
      logic [NA-1:0] nb;
      for (int k = 0; k < NA; k++) if (alu_ready[k] && !busy[k]) fr.push_back(k);
      for (int o = 0; o < NR; o++) if (req_valid[(rr + o) % NR]) rq.push_back((rr + o) % NR);
      n  = (fr.size() < rq.size()) ? fr.size() : rq.size();
      eg = '0;
      if (!reset && !flush) for (int j = 0; j < n; j++) eg[rq[j]] = 1'b1;
      chk("req_grant", req_grant, eg);
      chk("req_grant_narrow", req_grant_n, eg);
      chk("rs_valid", rs_valid, busy);
      chk("rs_valid_narrow", rs_valid_n, busy);
      for (int k = 0; k < NA; k++) begin
         chk("alu_payload_hold", alu_payload[k*PW +: PW], mdl_pl[k*PW +: PW]);
         chk("alu_payload_narrow", alu_payload_n[k*PW +: PW], mdl_pl[k*PW +: PW]);
      end
      chk("stall_cnt", stall_cnt, stall[31:0]);
      chk("stall_cnt_sat", stall_cnt_n, (stall > 7) ? 7 : stall);
      if (reset) begin
         busy = '0; rr = 0; stall = 0; mdl_pl = '0;
      end else if (flush) begin
         busy = '0;
      end else begin
         nb = '0;
         for (int j = 0; j < n; j++) begin
            nb[fr[j]] = 1'b1;
            mdl_pl[fr[j]*PW +: PW] = req_payload[rq[j]*PW +: PW];
            exp_q[fr[j]].push_back('{pl: req_payload[rq[j]*PW +: PW], cyc: cyc + 1});
         end
         if (n > 0) rr = (rq[n-1] + 1) % NR;
         if (rq.size() > 0 && fr.size() == 0) stall++;
         busy = nb;
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic [NR-1:0] rv, input logic [NA-1:0] ar);
      reset = r; flush = f; req_valid = rv; alu_ready = ar;
      for (int i = 0; i < NR; i++) begin
         logic [159:0] w;
         for (int b = 0; b < 5; b++) w[b*32 +: 32] = $urandom();
         req_payload[i*PW +: PW] = w[PW-1:0];
      end
      @(negedge clk);
      evaluate();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      drive(1, 0, 4'b1111, 2'b11);
      drive(1, 0, 4'b1111, 2'b11);
      drive(0, 0, 4'b1111, 2'b11);   // entries 0,1 -> ALU0/ALU1, rr_ptr=2
      drive(0, 0, 4'b0000, 2'b11);
      drive(0, 0, 4'b0100, 2'b11);   // entry 2 -> ALU0, rr_ptr=3
      drive(0, 0, 4'b0000, 2'b11);
      drive(0, 0, 4'b1011, 2'b11);   // wrap: entry 3 -> ALU0, entry 0 -> ALU1
      drive(0, 0, 4'b0000, 2'b11);
      repeat (5) drive(0, 0, 4'b0100, 2'b00);
      drive(0, 0, 4'b0100, 2'b10);   // entry 2 -> ALU1 only
      drive(0, 0, 4'b0000, 2'b11);
      drive(0, 0, 4'b0001, 2'b11);
      drive(0, 1, 4'b1111, 2'b11);   // flush right after a grant
      drive(0, 0, 4'b0000, 2'b11);
      drive(0, 0, 4'b0001, 2'b01);
      drive(0, 0, 4'b0001, 2'b01);   // ALU0 ready but still pulsing: no reissue
      drive(0, 0, 4'b0000, 2'b11);
      drive(0, 0, 4'b1111, 2'b11);
      drive(1, 0, 4'b1111, 2'b11);   // reset drops the pending pulse path
      repeat (10) drive(0, 0, 4'b1111, 2'b00);
      for (int c = 0; c < 3000; c++) begin
         logic [NA-1:0] ar;
         for (int k = 0; k < NA; k++) ar[k] = ($urandom_range(0, 3) != 0);
         drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
               NR'($urandom_range(0, (1 << NR) - 1)), ar);
      end
      repeat (3) drive(0, 0, 4'b0000, 2'b11);
      for (int k = 0; k < NA; k++) chk("queue_drained", PW'(exp_q[k].size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
